// File: rtl/riscv_hazard_pkg.sv
// Shared types and constants for the 5-stage RISC-V hazard/flush controller.
package riscv_hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } hz_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // M-stage result is newer than W-stage, so it wins when both match.
  function automatic fwd_sel_e fwd_sel(input logic [4:0] rs,
                                       input logic       reg_write_m,
                                       input logic [4:0] rd_m,
                                       input logic       reg_write_w,
                                       input logic [4:0] rd_w);
    if (reg_write_m && (rd_m != REG_ZERO) && (rd_m == rs))      return FWD_MEM;
    else if (reg_write_w && (rd_w != REG_ZERO) && (rd_w == rs)) return FWD_WB;
    else                                                        return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_mc_if.sv
// Hazard controller bundle: stage indices/control bits in, stall/flush/forward out.
// Optional perf counters appear when HAZARD_PERF_EN is defined.
interface hazard_ctrl_mc_if;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic        RegWriteM, RegWriteW, LoadE, PCSrcE, MdStartE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, StallE;
  logic        FlushD, FlushE, FlushM;
  logic        MdBusy, MdDoneE;
`ifdef HAZARD_PERF_EN
  logic [31:0] StallCycles, FlushCount;
`endif

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteM, RegWriteW, LoadE, PCSrcE, MdStartE,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE,
    input  FlushD, FlushE, FlushM, MdBusy, MdDoneE
`ifdef HAZARD_PERF_EN
    , input StallCycles, FlushCount
`endif
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteM, RegWriteW, LoadE, PCSrcE, MdStartE,
    output ForwardAE, ForwardBE, StallF, StallD, StallE,
    output FlushD, FlushE, FlushM, MdBusy, MdDoneE
`ifdef HAZARD_PERF_EN
    , output StallCycles, FlushCount
`endif
  );
endinterface

// File: rtl/hazard_md_timer.sv
// Multi-cycle execute sequencer: holds an op in E for MD_LATENCY cycles,
// stalling for the first MD_LATENCY-1 and pulsing done on the last.
import riscv_hazard_pkg::*;

module hazard_md_timer #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic stall,
  output logic done
);

  hz_state_e        state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // The start cycle counts as the first held cycle, hence the -2 preload.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    stall    = 1'b0;
    done     = 1'b0;
    busy     = 1'b0;
    case (state)
      RUN: begin
        stall = start;
        if (start) begin
          state_nx = MD_BUSY;
          cnt_nx   = CNT_W'(MD_LATENCY - 2);
        end
      end
      MD_BUSY: begin
        busy = 1'b1;
        if (cnt != '0) begin
          stall  = 1'b1;
          cnt_nx = cnt - CNT_W'(1);
        end else begin
          done     = 1'b1;
          state_nx = RUN;
        end
      end
      default: state_nx = RUN;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Hazard/flush controller for the 5-stage pipeline: forwarding, load-use,
// branch flush and mul/div stall. HAZARD_PERF_EN adds stall/flush counters.
import riscv_hazard_pkg::*;

module hazard_ctrl_mc #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 4
) (
  input  logic            clk,
  input  logic            reset,
  hazard_ctrl_mc_if.slave hz
);

  logic lw_stall, md_stall, md_busy, md_done;

  hazard_md_timer #(
    .MD_LATENCY (MD_LATENCY),
    .CNT_W      (CNT_W)
  ) u_md_timer (
    .clk   (clk),
    .reset (reset),
    .start (hz.MdStartE),
    .busy  (md_busy),
    .stall (md_stall),
    .done  (md_done)
  );

  assign hz.ForwardAE = fwd_sel(hz.Rs1E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
  assign hz.ForwardBE = fwd_sel(hz.Rs2E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);

  assign lw_stall = hz.LoadE && (hz.RdE != REG_ZERO) &&
                    ((hz.Rs1D == hz.RdE) || (hz.Rs2D == hz.RdE));

  assign hz.StallE  = md_stall;
  assign hz.FlushM  = md_stall;
  assign hz.StallF  = md_stall | lw_stall;
  assign hz.StallD  = md_stall | lw_stall;
  // A held register must never also be cleared, so mdStall masks both flushes.
  assign hz.FlushD  = hz.PCSrcE & ~md_stall;
  assign hz.FlushE  = (lw_stall | hz.PCSrcE) & ~md_stall;
  assign hz.MdBusy  = md_busy;
  assign hz.MdDoneE = md_done;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles, flush_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (hz.StallF && !(&stall_cycles))
        stall_cycles <= stall_cycles + 32'd1;
      if (hz.FlushE && hz.PCSrcE && !(&flush_count))
        flush_count <= flush_count + 32'd1;
    end
  end

  assign hz.StallCycles = stall_cycles;
  assign hz.FlushCount  = flush_count;
`endif

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Self-checking bench for hazard_ctrl_mc: directed scenarios plus random
// traffic against a cycles-remaining reference model.
module tb_hazard_ctrl_mc;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  hazard_ctrl_mc_if hz();

  hazard_ctrl_mc #(.MD_LATENCY(LAT), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  always #5 clk = ~clk;

  // Reference: number of cycles the current multi-cycle op still occupies E.
  int unsigned md_left = 0;
`ifdef HAZARD_PERF_EN
  logic [31:0] m_stalls = 0, m_flushes = 0;
`endif

  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
    if (hz.RegWriteM && hz.RdM != 0 && hz.RdM == rs) return 2'b10;
    if (hz.RegWriteW && hz.RdW != 0 && hz.RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  // {FwdA, FwdB, StallF, StallD, StallE, FlushD, FlushE, FlushM, MdBusy, MdDoneE}
  function automatic logic [11:0] model_out();
    logic md, done, busy, lw;
    lw   = hz.LoadE && hz.RdE != 0 && (hz.Rs1D == hz.RdE || hz.Rs2D == hz.RdE);
    busy = (md_left != 0);
    md   = busy ? (md_left > 1) : hz.MdStartE;
    done = (md_left == 1);
    return {m_fwd(hz.Rs1E), m_fwd(hz.Rs2E), md | lw, md | lw, md,
            hz.PCSrcE & ~md, (lw | hz.PCSrcE) & ~md, md, busy, done};
  endfunction

  function automatic logic [11:0] obs();
    return {hz.ForwardAE, hz.ForwardBE, hz.StallF, hz.StallD, hz.StallE,
            hz.FlushD, hz.FlushE, hz.FlushM, hz.MdBusy, hz.MdDoneE};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      md_left <= 0;
`ifdef HAZARD_PERF_EN
      m_stalls <= 0; m_flushes <= 0;
`endif
    end else begin
`ifdef HAZARD_PERF_EN
      begin
        logic [11:0] e;
        e = model_out();
        if (e[7] && m_stalls != 32'hFFFF_FFFF) m_stalls <= m_stalls + 1;
        if (e[3] && hz.PCSrcE && m_flushes != 32'hFFFF_FFFF) m_flushes <= m_flushes + 1;
      end
`endif
      if (md_left == 0) begin
        if (hz.MdStartE) md_left <= LAT - 1;
      end else md_left <= md_left - 1;
    end
  end

  task automatic set_idle();
    hz.Rs1D = 0; hz.Rs2D = 0; hz.Rs1E = 0; hz.Rs2E = 0;
    hz.RdE = 0; hz.RdM = 0; hz.RdW = 0;
    hz.RegWriteM = 0; hz.RegWriteW = 0; hz.LoadE = 0; hz.PCSrcE = 0; hz.MdStartE = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    set_idle();
    reset = 1'b1;
    #2;
    if (obs() !== 12'h000) begin errors++; $display("FAIL reset_outputs got=%h exp=%h", obs(), 12'h000); end
    checks++;
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_forwarding();
    logic [1:0] exp_a [3] = '{2'b10, 2'b01, 2'b00};
    set_idle();
    for (int i = 0; i < 3; i++) begin
      hz.RegWriteM = 1; hz.RegWriteW = 1;
      hz.RdM  = (i == 0) ? 5'd5 : 5'd0;
      hz.RdW  = (i == 2) ? 5'd0 : 5'd5;
      hz.Rs1E = (i == 2) ? 5'd0 : 5'd5;
      hz.Rs2E = 5'd5;
      @(negedge clk);
      if (hz.ForwardAE !== exp_a[i]) begin
        errors++; $display("FAIL fwd_a_step%0d got=%b exp=%b", i, hz.ForwardAE, exp_a[i]);
      end
      checks++;
      if (obs() !== model_out()) begin
        errors++; $display("FAIL fwd_step%0d got=%h exp=%h", i, obs(), model_out());
      end
      checks++;
      next_cycle();
    end
    set_idle();
  endtask

  task automatic test_load_use();
    logic [11:0] e;
    set_idle();
    for (int i = 0; i < 2; i++) begin
      hz.LoadE = 1; hz.RdE = (i == 0) ? 5'd7 : 5'd0; hz.Rs2D = hz.RdE;
      @(negedge clk);
      e = (i == 0) ? 12'b0000_1100_1000 : 12'h000;
      if (obs() !== e) begin errors++; $display("FAIL load_use%0d got=%b exp=%b", i, obs(), e); end
      checks++;
      next_cycle();
    end
    set_idle();
  endtask

  task automatic test_branch();
    set_idle();
    hz.PCSrcE = 1;
    @(negedge clk);
    if (obs() !== 12'b0000_0001_1000) begin
      errors++; $display("FAIL branch_flush got=%b exp=%b", obs(), 12'b0000_0001_1000);
    end
    checks++;
    next_cycle();
    set_idle();
  endtask

  // Two ops back to back with MdStartE held throughout.
  task automatic test_back_to_back();
    set_idle();
    hz.MdStartE = 1;
    for (int i = 0; i < 2 * LAT; i++) begin
      @(negedge clk);
      if (hz.StallE !== (i % LAT != LAT - 1) || hz.FlushM !== hz.StallE ||
          hz.MdDoneE !== (i % LAT == LAT - 1) || hz.MdBusy !== (i % LAT != 0)) begin
        errors++;
        $display("FAIL md_pattern cyc%0d got stallE=%b flushM=%b done=%b busy=%b", i,
                 hz.StallE, hz.FlushM, hz.MdDoneE, hz.MdBusy);
      end
      checks++;
      next_cycle();
    end
    set_idle();
    @(negedge clk);
    if (hz.MdBusy !== 1'b0 || hz.StallE !== 1'b0) begin
      errors++; $display("FAIL md_back_to_run busy=%b stallE=%b exp=0", hz.MdBusy, hz.StallE);
    end
    checks++;
    next_cycle();
  endtask

  task automatic test_overlap();
    set_idle();
    hz.MdStartE = 1;
    next_cycle();
    hz.LoadE = 1; hz.RdE = 5'd7; hz.Rs1D = 5'd7; hz.PCSrcE = 1;
    @(negedge clk);
    if (hz.FlushE !== 0 || hz.FlushD !== 0 || hz.StallE !== 1 || hz.StallF !== 1) begin
      errors++; $display("FAIL overlap flushE=%b flushD=%b stallE=%b stallF=%b exp=0,0,1,1",
                         hz.FlushE, hz.FlushD, hz.StallE, hz.StallF);
    end
    checks++;
    if (obs() !== model_out()) begin errors++; $display("FAIL overlap_model got=%h exp=%h", obs(), model_out()); end
    checks++;
    hz.LoadE = 0; hz.PCSrcE = 0;
    for (int i = 0; i < LAT - 1; i++) next_cycle();
    set_idle();
    next_cycle();
  endtask

  task automatic test_reset_mid();
    set_idle();
    hz.MdStartE = 1;
    next_cycle();
    next_cycle();
    #2;
    set_idle();
    reset = 1'b1;
    #1;
    if (obs() !== 12'h000) begin errors++; $display("FAIL reset_mid got=%b exp=0", obs()); end
    checks++;
    next_cycle();
    reset = 1'b0;
    hz.MdStartE = 1;
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk);
      if (hz.StallE !== (i != LAT - 1) || hz.MdDoneE !== (i == LAT - 1)) begin
        errors++; $display("FAIL reset_restart cyc%0d stallE=%b done=%b", i, hz.StallE, hz.MdDoneE);
      end
      checks++;
      next_cycle();
    end
    set_idle();
    next_cycle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      hz.Rs1D = 5'($urandom_range(0, 3)); hz.Rs2D = 5'($urandom_range(0, 3));
      hz.Rs1E = 5'($urandom_range(0, 3)); hz.Rs2E = 5'($urandom_range(0, 3));
      hz.RdE  = 5'($urandom_range(0, 3)); hz.RdM  = 5'($urandom_range(0, 3));
      hz.RdW  = 5'($urandom_range(0, 3));
      hz.RegWriteM = 1'($urandom); hz.RegWriteW = 1'($urandom);
      hz.LoadE = 1'($urandom); hz.PCSrcE = ($urandom_range(0, 3) == 0);
      hz.MdStartE = ($urandom_range(0, 5) == 0);
      @(negedge clk);
      if (obs() !== model_out()) begin errors++; $display("FAIL random%0d got=%b exp=%b", n, obs(), model_out()); end
      checks++;
      next_cycle();
    end
    set_idle();
    for (int i = 0; i < LAT; i++) next_cycle();
`ifdef HAZARD_PERF_EN
    if (hz.StallCycles !== m_stalls || hz.FlushCount !== m_flushes) begin
      errors++; $display("FAIL perf got=%0d/%0d exp=%0d/%0d", hz.StallCycles, hz.FlushCount, m_stalls, m_flushes);
    end
    checks++;
`endif
  endtask

  initial begin
    set_idle();
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_back_to_back();
    test_overlap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_mc.md
Name: hazard_ctrl_mc

Overview:
- Hazard and flush controller for the 5-stage RISC-V pipeline.
- Generates the stall, clear and forwarding controls consumed by the IF/ID, ID/EX, EX/MEM and fetch registers.
- Covers three hazards: load-use, taken-branch flush, and a multi-cycle execute stall (mul/div) sequenced by an internal FSM and down-counter.
- Sits beside the datapath; inputs are register indices and control bits from the D, E, M and W stages.

Parameters:
- MD_LATENCY, 4: number of cycles a multi-cycle op occupies E. Legal range 2..16.
- CNT_W, 4: width of the multi-cycle down-counter. Must satisfy 2**CNT_W >= MD_LATENCY.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- Rs1D  in  5  source reg 1 of the instruction in D
- Rs2D  in  5  source reg 2 of the instruction in D
- Rs1E  in  5  source reg 1 in E
- Rs2E  in  5  source reg 2 in E
- RdE  in  5  destination reg in E
- RdM  in  5  destination reg in M
- RdW  in  5  destination reg in W
- RegWriteM  in  1  M-stage instruction writes Rd
- RegWriteW  in  1  W-stage instruction writes Rd
- LoadE  in  1  E-stage instruction is a load
- PCSrcE  in  1  taken branch/jump resolved in E
- MdStartE  in  1  E-stage instruction is a multi-cycle op
- ForwardAE  out  2  operand A select: 00 regfile, 01 W result, 10 M ALU result
- ForwardBE  out  2  operand B select, same encoding
- StallF  out  1  hold PC
- StallD  out  1  hold IF/ID
- StallE  out  1  hold ID/EX
- FlushD  out  1  clear IF/ID
- FlushE  out  1  clear ID/EX (drives its clear input)
- FlushM  out  1  clear EX/MEM (inserts bubble)
- MdBusy  out  1  FSM is in MD_BUSY
- MdDoneE  out  1  one-cycle pulse on the final cycle of a multi-cycle op

Behaviour:
- Reset: state = RUN, cnt = 0. With idle inputs all outputs are 0 (Forward* = 00).
- Forwarding (combinational), per operand X in {1,2}:
  - 10 if RegWriteM && RdM != 0 && RdM == RsXE.
  - else 01 if RegWriteW && RdW != 0 && RdW == RsXE.
  - else 00.
  - M has priority over W.
- lwStall = LoadE && RdE != 0 && (Rs1D == RdE || Rs2D == RdE).
- mdStall:
  - In RUN: equals MdStartE.
  - In MD_BUSY: equals (cnt != 0).
- Output equations:
  - StallE = FlushM = mdStall.
  - StallF = StallD = mdStall | lwStall.
  - FlushD = PCSrcE & ~mdStall.
  - FlushE = (lwStall | PCSrcE) & ~mdStall. Never flush a held register.
- FSM transition RUN -> MD_BUSY: when MdStartE; load cnt = MD_LATENCY-2 on the same edge.
- FSM in MD_BUSY:
  - cnt != 0: decrement.
  - cnt == 0: MdDoneE = 1, stalls drop, the op advances, next state RUN.
  - MdStartE is ignored in MD_BUSY, so the held op does not retrigger.
- Timing: the op holds E for exactly MD_LATENCY cycles. Stall asserts for MD_LATENCY-1 cycles, starting combinationally in the first cycle.
- Back-to-back multi-cycle ops: the second is seen in RUN on the cycle after MdDoneE and restarts normally.
- MD_LATENCY = 2: cnt loads 0; MD_BUSY lasts one cycle with stalls deasserted.
- Reset mid-operation: returns to RUN immediately (asynchronous); cnt cleared; MdBusy = 0.
- PCSrcE and MdStartE are mutually exclusive by ISA decode. If both are seen in RUN, the multi-cycle op wins and the flush is suppressed.

Optional Feature:
- Macro HAZARD_PERF_EN.
- When defined: adds outputs StallCycles[31:0] (increments on every cycle StallF=1) and FlushCount[31:0] (increments on every cycle FlushE=1 with PCSrcE=1). Both saturate at all-ones and reset to 0 on reset.
- When undefined: the ports and counters do not exist.

Decomposition:
- Package riscv_hazard_pkg holds:
  - fwd_sel_e enum: FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
  - hz_state_e enum: RUN, MD_BUSY.
  - REG_ZERO constant = 5'd0.
- Sub-module hazard_md_timer holds the FSM and down-counter. Interface: start in, busy/stall/done out, parameter MD_LATENCY. The top level keeps the forwarding and flush logic.

Test Plan:
- Forwarding: RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 -> ForwardAE=10. Then RdM=0 -> ForwardAE=01. Then Rs1E=0 with RdW=0 -> ForwardAE=00.
- Load-use: LoadE=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle. With RdE=0 -> no stall.
- Branch: PCSrcE=1 for one cycle -> FlushD=FlushE=1 that cycle, no stalls.
- Multi-cycle op, MD_LATENCY=4: MdStartE held while E holds -> StallE/FlushM high for 3 cycles, MdDoneE pulses on cycle 4, state back to RUN. A second op right after gives an identical 3-cycle pattern.
- Overlap: load-use condition plus PCSrcE during MD_BUSY -> FlushE=FlushD=0 while StallE=1.
- Reset asserted in the 2nd cycle of MD_BUSY -> all outputs 0 asynchronously, MdBusy=0. After release, a fresh MdStartE gives the full 3-cycle stall.
